hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/swt16_pkg.sv | 27 ++
 rtl/hazard_ctrl_fwd_match.sv | 48 ++++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swt16_pkg.sv
// ============================================================================
// Module   : swt16_pkg
// Brief    : Shared pipeline-control types and constants: hazard FSM state
//            encoding and operand forwarding select codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package swt16_pkg;

    // Hazard controller FSM, 2-bit encoding with fixed code points
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2
    } hz_state_t;

    // Operand source select seen by the decode/exec operand muxes
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = 2'd0;
    localparam fwd_sel_t FWD_EX      = 2'd1;
    localparam fwd_sel_t FWD_MEM     = 2'd2;

endpackage : swt16_pkg

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_match.sv
// ============================================================================
// Module   : fwd_match
// Brief    : Per-operand forwarding comparator. Picks the youngest in-flight
//            producer of the operand: exec (non-load) first, then mem, else
//            the register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_match
    import swt16_pkg::*;
#(
    parameter int REG_IDX_WIDTH = 4
) (
    input  logic                     i_dec_valid,
    input  logic                     i_uses_src,
    input  logic [REG_IDX_WIDTH-1:0] i_src_idx,
    input  logic                     i_ex_write,
    input  logic                     i_ex_load,
    input  logic [REG_IDX_WIDTH-1:0] i_ex_idx,
    input  logic                     i_mem_write,
    input  logic [REG_IDX_WIDTH-1:0] i_mem_idx,
    input  logic                     i_block,
    output fwd_sel_t                 o_fwd_sel
);

    logic w_ex_hit;
    logic w_mem_hit;

    // A load in exec has no data yet, so it never forwards from exec
    assign w_ex_hit  = i_ex_write & ~i_ex_load & (i_ex_idx == i_src_idx);
    assign w_mem_hit = i_mem_write & (i_mem_idx == i_src_idx);

    // Priority select: exec is the younger producer and wins a double match
    always_comb begin
        o_fwd_sel = FWD_REGFILE;
        if (i_dec_valid && i_uses_src && !i_block) begin
            if (w_ex_hit) begin
                o_fwd_sel = FWD_EX;
            end else if (w_mem_hit) begin
                o_fwd_sel = FWD_MEM;
            end
        end
    end

endmodule : fwd_match

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard controller. Detects load-use hazards (one-cycle
//            stall + exec bubble), handles exec-stage redirects (flush window
//            of FLUSH_CYCLES cycles including the redirect cycle) and drives
//            the operand forwarding selects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import swt16_pkg::*;
#(
    parameter int REG_IDX_WIDTH = 4,
    parameter int PC_WIDTH      = 12,
    parameter int FLUSH_CYCLES  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_dec_valid,
    input  logic                     in_dec_uses_src1,
    input  logic                     in_dec_uses_src2,
    input  logic [REG_IDX_WIDTH-1:0] in_dec_src1_idx,
    input  logic [REG_IDX_WIDTH-1:0] in_dec_src2_idx,
    input  logic                     in_ex_act_write_res_to_reg,
    input  logic                     in_ex_act_load_dmem,
    input  logic [REG_IDX_WIDTH-1:0] in_ex_res_reg_idx,
    input  logic                     in_mem_act_write_res_to_reg,
    input  logic [REG_IDX_WIDTH-1:0] in_mem_res_reg_idx,
    input  logic                     in_set_pc,
    input  logic [PC_WIDTH-1:0]      in_branch_pc,
    output logic                     out_stall_fetch,
    output logic                     out_stall_decode,
    output logic                     out_bubble_exec,
    output logic                     out_flush_front,
    output logic [1:0]               out_fwd_sel_src1,
    output logic [1:0]               out_fwd_sel_src2,
    output logic                     out_set_pc,
    output logic [PC_WIDTH-1:0]      out_branch_pc
);

    // Counter reload: cycles still to spend in FLUSH after the redirect cycle
    localparam logic [2:0] c_cnt_load = 3'(FLUSH_CYCLES - 1);

    hz_state_t r_state;
    hz_state_t w_state_next;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_next;

    logic w_load_use;
    logic w_fwd_block;

    logic                     w_uses  [2];
    logic [REG_IDX_WIDTH-1:0] w_idx   [2];
    fwd_sel_t                 w_fwd_sel [2];

    assign w_load_use = in_dec_valid & in_ex_act_load_dmem & in_ex_act_write_res_to_reg &
                        ((in_dec_uses_src1 & (in_dec_src1_idx == in_ex_res_reg_idx)) |
                         (in_dec_uses_src2 & (in_dec_src2_idx == in_ex_res_reg_idx)));

    // Decode contents are being squashed in FLUSH, and reset zeroes all outputs
    assign w_fwd_block = reset | (r_state == ST_FLUSH);

    assign w_uses[0] = in_dec_uses_src1;
    assign w_uses[1] = in_dec_uses_src2;
    assign w_idx[0]  = in_dec_src1_idx;
    assign w_idx[1]  = in_dec_src2_idx;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_fwd
            fwd_match #(
                .REG_IDX_WIDTH (REG_IDX_WIDTH)
            ) u_fwd_match (
                .i_dec_valid (in_dec_valid),
                .i_uses_src  (w_uses[g]),
                .i_src_idx   (w_idx[g]),
                .i_ex_write  (in_ex_act_write_res_to_reg),
                .i_ex_load   (in_ex_act_load_dmem),
                .i_ex_idx    (in_ex_res_reg_idx),
                .i_mem_write (in_mem_act_write_res_to_reg),
                .i_mem_idx   (in_mem_res_reg_idx),
                .i_block     (w_fwd_block),
                .o_fwd_sel   (w_fwd_sel[g])
            );
        end
    endgenerate

    assign out_fwd_sel_src1 = w_fwd_sel[0];
    assign out_fwd_sel_src2 = w_fwd_sel[1];

    // State and flush counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state and stall/flush/redirect outputs; a redirect outranks everything
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        out_stall_fetch  = 1'b0;
        out_stall_decode = 1'b0;
        out_bubble_exec  = 1'b0;
        out_flush_front  = 1'b0;
        out_set_pc       = 1'b0;
        out_branch_pc    = '0;
        if (reset) begin
            w_state_next = ST_RUN;
            w_cnt_next   = 3'd0;
        end else if (in_set_pc) begin
            out_set_pc      = 1'b1;
            out_branch_pc   = in_branch_pc;
            out_flush_front = 1'b1;
            out_bubble_exec = (r_state == ST_FLUSH);
            w_cnt_next      = c_cnt_load;
            w_state_next    = ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_load_use) begin
                        out_stall_fetch  = 1'b1;
                        out_stall_decode = 1'b1;
                        out_bubble_exec  = 1'b1;
                        w_state_next     = ST_LOAD_STALL;
                    end
                end
                ST_LOAD_STALL: begin
                    // Load has moved to mem; operand now comes via mem forwarding
                    w_state_next = ST_RUN;
                end
                ST_FLUSH: begin
                    out_flush_front = 1'b1;
                    out_bubble_exec = 1'b1;
                    // Leave once this cycle's decrement brings the counter to 0
                    if (r_cnt <= 3'd1) begin
                        w_cnt_next   = 3'd0;
                        w_state_next = ST_RUN;
                    end else begin
                        w_cnt_next = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_cnt_next   = 3'd0;
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

endmodule : hazard_ctrl

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl: a cycle-level reference
//            model compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int RW = 4;
    localparam int PW = 12;
    localparam int FC = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_dec_valid, in_dec_uses_src1, in_dec_uses_src2;
    logic [RW-1:0] in_dec_src1_idx, in_dec_src2_idx;
    logic          in_ex_act_write_res_to_reg, in_ex_act_load_dmem;
    logic [RW-1:0] in_ex_res_reg_idx;
    logic          in_mem_act_write_res_to_reg;
    logic [RW-1:0] in_mem_res_reg_idx;
    logic          in_set_pc;
    logic [PW-1:0] in_branch_pc;
    logic          out_stall_fetch, out_stall_decode, out_bubble_exec, out_flush_front;
    logic [1:0]    out_fwd_sel_src1, out_fwd_sel_src2;
    logic          out_set_pc;
    logic [PW-1:0] out_branch_pc;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl #(
        .REG_IDX_WIDTH (RW),
        .PC_WIDTH      (PW),
        .FLUSH_CYCLES  (FC)
    ) dut (
        .clock                       (clock),
        .reset                       (reset),
        .in_dec_valid                (in_dec_valid),
        .in_dec_uses_src1            (in_dec_uses_src1),
        .in_dec_uses_src2            (in_dec_uses_src2),
        .in_dec_src1_idx             (in_dec_src1_idx),
        .in_dec_src2_idx             (in_dec_src2_idx),
        .in_ex_act_write_res_to_reg  (in_ex_act_write_res_to_reg),
        .in_ex_act_load_dmem         (in_ex_act_load_dmem),
        .in_ex_res_reg_idx           (in_ex_res_reg_idx),
        .in_mem_act_write_res_to_reg (in_mem_act_write_res_to_reg),
        .in_mem_res_reg_idx          (in_mem_res_reg_idx),
        .in_set_pc                   (in_set_pc),
        .in_branch_pc                (in_branch_pc),
        .out_stall_fetch             (out_stall_fetch),
        .out_stall_decode            (out_stall_decode),
        .out_bubble_exec             (out_bubble_exec),
        .out_flush_front             (out_flush_front),
        .out_fwd_sel_src1            (out_fwd_sel_src1),
        .out_fwd_sel_src2            (out_fwd_sel_src2),
        .out_set_pc                  (out_set_pc),
        .out_branch_pc               (out_branch_pc)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: remaining flush cycles and whether the previous
    // cycle was a load-use stall (a stall lasts exactly one cycle).
    // ------------------------------------------------------------------
    int m_flush_left = 0;
    bit m_was_stall  = 1'b0;

    function automatic logic model_load_use();
        return in_dec_valid && in_ex_act_load_dmem && in_ex_act_write_res_to_reg &&
               ((in_dec_uses_src1 && (in_dec_src1_idx == in_ex_res_reg_idx)) ||
                (in_dec_uses_src2 && (in_dec_src2_idx == in_ex_res_reg_idx)));
    endfunction

    function automatic logic model_flushing();
        return !reset && (m_flush_left > 0);
    endfunction

    function automatic logic model_stall();
        return !reset && !in_set_pc && !model_flushing() && !m_was_stall && model_load_use();
    endfunction

    function automatic logic [1:0] model_fwd(input logic uses, input logic [RW-1:0] idx);
        if (reset || !in_dec_valid || !uses || model_flushing()) return 2'd0;
        if (in_ex_act_write_res_to_reg && !in_ex_act_load_dmem && (in_ex_res_reg_idx == idx))
            return 2'd1;
        if (in_mem_act_write_res_to_reg && (in_mem_res_reg_idx == idx)) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_flush_left <= 0;
            m_was_stall  <= 1'b0;
        end else begin
            m_was_stall <= model_stall();
            if (in_set_pc) m_flush_left <= FC - 1;
            else if (m_flush_left > 0) m_flush_left <= m_flush_left - 1;
        end
    end

    // Every-cycle comparison against the model, mid-cycle
    always @(negedge clock) begin
        check("m_stall_fetch",  32'(out_stall_fetch),  32'(model_stall()));
        check("m_stall_decode", 32'(out_stall_decode), 32'(model_stall()));
        check("m_bubble_exec",  32'(out_bubble_exec),  32'(model_flushing() || model_stall()));
        check("m_flush_front",  32'(out_flush_front),  32'(!reset && (in_set_pc || model_flushing())));
        check("m_set_pc",       32'(out_set_pc),       32'(!reset && in_set_pc));
        check("m_branch_pc",    32'(out_branch_pc),    32'((!reset && in_set_pc) ? in_branch_pc : '0));
        check("m_fwd1",         32'(out_fwd_sel_src1), 32'(model_fwd(in_dec_uses_src1, in_dec_src1_idx)));
        check("m_fwd2",         32'(out_fwd_sel_src2), 32'(model_fwd(in_dec_uses_src2, in_dec_src2_idx)));
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic idle();
        in_dec_valid = 1'b0; in_dec_uses_src1 = 1'b0; in_dec_uses_src2 = 1'b0;
        in_dec_src1_idx = '0; in_dec_src2_idx = '0;
        in_ex_act_write_res_to_reg = 1'b0; in_ex_act_load_dmem = 1'b0; in_ex_res_reg_idx = '0;
        in_mem_act_write_res_to_reg = 1'b0; in_mem_res_reg_idx = '0;
        in_set_pc = 1'b0; in_branch_pc = '0;
    endtask

    task automatic dec(input logic u1, input logic [RW-1:0] s1, input logic u2, input logic [RW-1:0] s2);
        in_dec_valid = 1'b1;
        in_dec_uses_src1 = u1; in_dec_src1_idx = s1;
        in_dec_uses_src2 = u2; in_dec_src2_idx = s2;
    endtask

    task automatic ex(input logic wr, input logic ld, input logic [RW-1:0] idx);
        in_ex_act_write_res_to_reg = wr; in_ex_act_load_dmem = ld; in_ex_res_reg_idx = idx;
    endtask

    task automatic mem(input logic wr, input logic [RW-1:0] idx);
        in_mem_act_write_res_to_reg = wr; in_mem_res_reg_idx = idx;
    endtask

    task automatic redirect(input logic [PW-1:0] pc);
        in_set_pc = 1'b1; in_branch_pc = pc;
    endtask

    task automatic mid();
        @(negedge clock); #1;
    endtask

    task automatic next_cycle();
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        // Reset held with noisy inputs: everything stays 0
        redirect(12'h5A5); dec(1'b1, 4'd3, 1'b0, 4'd0); ex(1'b1, 1'b1, 4'd3); mem(1'b1, 4'd3);
        mid();
        check("rst_set_pc", 32'(out_set_pc), 32'd0);
        check("rst_branch_pc", 32'(out_branch_pc), 32'd0);
        check("rst_stall", 32'(out_stall_fetch), 32'd0);
        check("rst_fwd1", 32'(out_fwd_sel_src1), 32'd0);
        next_cycle(); reset = 1'b0; idle();
        mid();
        check("idle_flush", 32'(out_flush_front), 32'd0);
        next_cycle();

        // Load r3 in exec, decode reads r3 -> one stall cycle, then mem forward
        idle(); dec(1'b1, 4'd3, 1'b0, 4'd0); ex(1'b1, 1'b1, 4'd3);
        mid();
        check("lu_stall_fetch", 32'(out_stall_fetch), 32'd1);
        check("lu_stall_decode", 32'(out_stall_decode), 32'd1);
        check("lu_bubble", 32'(out_bubble_exec), 32'd1);
        next_cycle();
        idle(); dec(1'b1, 4'd3, 1'b0, 4'd0); mem(1'b1, 4'd3);
        mid();
        check("ls_stall", 32'(out_stall_fetch), 32'd0);
        check("ls_bubble", 32'(out_bubble_exec), 32'd0);
        check("ls_fwd1", 32'(out_fwd_sel_src1), 32'd2);
        next_cycle();

        // Double match on r5: exec wins, no stall
        idle(); dec(1'b0, 4'd0, 1'b1, 4'd5); ex(1'b1, 1'b0, 4'd5); mem(1'b1, 4'd5);
        mid();
        check("dbl_fwd2", 32'(out_fwd_sel_src2), 32'd1);
        check("dbl_stall", 32'(out_stall_fetch), 32'd0);
        next_cycle();
        ex(1'b1, 1'b0, 4'd6);
        mid();
        check("mem_fwd2", 32'(out_fwd_sel_src2), 32'd2);
        next_cycle();
        // Load in exec + mem also writing r5: stall, operand selected from mem
        ex(1'b1, 1'b1, 4'd5);
        mid();
        check("lu2_stall", 32'(out_stall_decode), 32'd1);
        check("lu2_fwd2", 32'(out_fwd_sel_src2), 32'd2);
        next_cycle();
        idle(); dec(1'b0, 4'd0, 1'b0, 4'd5); mem(1'b1, 4'd5);
        mid();
        check("unused_fwd2", 32'(out_fwd_sel_src2), 32'd0);
        next_cycle();

        // Redirect to 0x0A4: two-cycle flush window then RUN
        idle(); redirect(12'h0A4);
        mid();
        check("br_set_pc", 32'(out_set_pc), 32'd1);
        check("br_pc", 32'(out_branch_pc), 32'h0A4);
        check("br_flush0", 32'(out_flush_front), 32'd1);
        next_cycle();
        idle();
        mid();
        check("br_set_pc_off", 32'(out_set_pc), 32'd0);
        check("br_pc_off", 32'(out_branch_pc), 32'd0);
        check("br_flush1", 32'(out_flush_front), 32'd1);
        check("br_bubble1", 32'(out_bubble_exec), 32'd1);
        next_cycle();
        mid();
        check("br_flush2", 32'(out_flush_front), 32'd0);
        next_cycle();

        // Redirect together with load-use: flush wins, no stall
        idle(); redirect(12'h123); dec(1'b1, 4'd3, 1'b0, 4'd0); ex(1'b1, 1'b1, 4'd3);
        mid();
        check("brlu_flush", 32'(out_flush_front), 32'd1);
        check("brlu_stall_f", 32'(out_stall_fetch), 32'd0);
        check("brlu_stall_d", 32'(out_stall_decode), 32'd0);
        next_cycle();
        in_set_pc = 1'b0; in_branch_pc = '0; mem(1'b1, 4'd3);
        mid();
        check("brlu_flush1", 32'(out_flush_front), 32'd1);
        check("brlu_stall1", 32'(out_stall_fetch), 32'd0);
        check("brlu_fwd1", 32'(out_fwd_sel_src1), 32'd0);
        next_cycle();
        idle();
        mid();
        check("brlu_run", 32'(out_flush_front), 32'd0);
        next_cycle();

        // Second redirect in the 2nd flush cycle restarts the window
        idle(); redirect(12'h010);
        mid();
        check("rr_flush0", 32'(out_flush_front), 32'd1);
        next_cycle();
        redirect(12'h020);
        mid();
        check("rr_flush1", 32'(out_flush_front), 32'd1);
        check("rr_pc", 32'(out_branch_pc), 32'h020);
        next_cycle();
        idle();
        mid();
        check("rr_flush2", 32'(out_flush_front), 32'd1);
        next_cycle();
        mid();
        check("rr_flush3", 32'(out_flush_front), 32'd0);
        next_cycle();

        // Reset pulse during LOAD_STALL
        idle(); dec(1'b1, 4'd3, 1'b0, 4'd0); ex(1'b1, 1'b1, 4'd3);
        mid();
        check("rs_stall", 32'(out_stall_fetch), 32'd1);
        next_cycle();
        idle(); dec(1'b1, 4'd3, 1'b0, 4'd0); mem(1'b1, 4'd3); reset = 1'b1;
        mid();
        check("rs_fwd1", 32'(out_fwd_sel_src1), 32'd0);
        check("rs_bubble", 32'(out_bubble_exec), 32'd0);
        next_cycle();
        reset = 1'b0; idle(); dec(1'b1, 4'd3, 1'b0, 4'd0); ex(1'b1, 1'b1, 4'd3);
        mid();
        check("rs_run_stall", 32'(out_stall_fetch), 32'd1);
        next_cycle();
        idle();
        next_cycle();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_hazard_ctrl

`default_nettype wire
